// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add multiply (LSB first) and restoring divide, one bit per clock.
module alu_seq_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_div,
    input  logic               i_run,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_last
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sh_nxt;

    // r_acc is the product high half (mul) or the partial remainder (div);
    // r_sh shifts out multiplier bits or dividend bits and shifts in quotient bits.
    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_b} : '0);
        w_trial = {r_acc, r_sh[WIDTH-1]};
        w_diff  = w_trial - {1'b0, r_b};
        if (r_div) begin
            w_acc_nxt = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_sh_nxt  = {r_sh[WIDTH-2:0], ~w_diff[WIDTH]};
        end else begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_sh_nxt  = {w_sum[0], r_sh[WIDTH-1:1]};
        end
    end

    assign o_result = {w_acc_nxt, w_sh_nxt};
    assign o_last   = i_run && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_sh  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_start) begin
            r_acc <= '0;
            r_sh  <= i_div ? i_a : i_b;
            r_b   <= i_div ? i_b : i_a;
            r_cnt <= CNT_W'(WIDTH - 1);
            r_div <= i_div;
        end else if (i_run) begin
            r_acc <= w_acc_nxt;
            r_sh  <= w_sh_nxt;
            if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// Sequential ALU top: FSM, single-cycle ops and flag registers.
// Build option: define SHIFT_OPS_EN to enable SHL/SHR opcodes.
//
// state  | meaning
// S_IDLE | waiting for bgn; accepts and latches an op
// S_MUL  | WIDTH iterations of shift-add multiply
// S_DIV  | WIDTH iterations of restoring divide
// S_DONE | one-cycle result-valid pulse
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bgn,
    input  logic [3:0]               control,
    input  logic [$clog2(WIDTH)-1:0] pos,
    input  logic [WIDTH-1:0]         nr1,
    input  logic [WIDTH-1:0]         nr2,
    output logic                     busy,
    output logic                     done,
    output logic [2*WIDTH-1:0]       outbus,
    output logic                     carry_next,
    output logic                     borrow_next,
    output logic                     neg,
    output logic                     dz,
    output logic                     ill
);

    state_t r_state;
    state_t w_state_nxt;

    logic [2*WIDTH-1:0] r_outbus;
    logic               r_carry;
    logic               r_borrow;
    logic               r_neg;
    logic               r_dz;
    logic               r_ill;

    logic               w_accept;
    logic               w_md_start;
    logic               w_md_run;
    logic               w_md_last;
    logic [2*WIDTH-1:0] w_md_result;

    logic [2*WIDTH-1:0] w_sc_res;
    logic               w_sc_carry;
    logic               w_sc_borrow;
    logic               w_sc_neg;
    logic               w_sc_dz;
    logic               w_sc_ill;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;

    assign w_accept   = (r_state == S_IDLE) && bgn;
    assign w_md_start = w_accept && ((control == OP_MUL) ||
                                     ((control == OP_DIV) && (nr2 != '0)));
    assign w_md_run   = (r_state == S_MUL) || (r_state == S_DIV);

    alu_seq_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_div    (control == OP_DIV),
        .i_run    (w_md_run),
        .i_a      (nr1),
        .i_b      (nr2),
        .o_result (w_md_result),
        .o_last   (w_md_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bgn) begin
                    if (control == OP_MUL)
                        w_state_nxt = S_MUL;
                    else if ((control == OP_DIV) && (nr2 != '0))
                        w_state_nxt = S_DIV;
                    else
                        w_state_nxt = S_DONE;
                end
            end
            S_MUL, S_DIV: begin
                if (w_md_last)
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_MUL) || (r_state == S_DIV);
        done = (r_state == S_DONE);
    end

    // Result and flags captured at accept; mul/div overwrite outbus on the last iteration.
    always_comb begin
        w_add       = {1'b0, nr1} + {1'b0, nr2};
        w_sub       = {1'b0, nr1} - {1'b0, nr2};
        w_sc_res    = '0;
        w_sc_carry  = 1'b0;
        w_sc_borrow = 1'b0;
        w_sc_neg    = 1'b0;
        w_sc_dz     = 1'b0;
        w_sc_ill    = 1'b0;
        case (control)
            OP_ADD: begin
                w_sc_res   = {{WIDTH{1'b0}}, w_add[WIDTH-1:0]};
                w_sc_carry = w_add[WIDTH];
                w_sc_neg   = w_add[WIDTH-1];
            end
            OP_SUB: begin
                w_sc_res    = {{WIDTH{1'b0}}, w_sub[WIDTH-1:0]};
                w_sc_borrow = w_sub[WIDTH];
                w_sc_neg    = w_sub[WIDTH-1];
            end
            OP_MUL: w_sc_res = '0;
            OP_DIV: begin
                if (nr2 == '0) begin
                    w_sc_res = {nr1, {WIDTH{1'b1}}};
                    w_sc_dz  = 1'b1;
                end
            end
            OP_AND: w_sc_res = {{WIDTH{1'b0}}, nr1 & nr2};
            OP_OR:  w_sc_res = {{WIDTH{1'b0}}, nr1 | nr2};
            OP_XOR: w_sc_res = {{WIDTH{1'b0}}, nr1 ^ nr2};
`ifdef SHIFT_OPS_EN
            OP_SHL: w_sc_res = {{WIDTH{1'b0}}, nr1 << pos};
            OP_SHR: w_sc_res = {{WIDTH{1'b0}}, nr1 >> pos};
`endif
            default: w_sc_ill = 1'b1;
        endcase
    end

`ifndef SHIFT_OPS_EN
    logic w_unused_pos;
    assign w_unused_pos = ^pos;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outbus <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ill    <= 1'b0;
        end else if (w_accept) begin
            r_outbus <= w_sc_res;
            r_carry  <= w_sc_carry;
            r_borrow <= w_sc_borrow;
            r_neg    <= w_sc_neg;
            r_dz     <= w_sc_dz;
            r_ill    <= w_sc_ill;
        end else if (w_md_last) begin
            r_outbus <= w_md_result;
        end
    end

    assign outbus      = r_outbus;
    assign carry_next  = r_carry;
    assign borrow_next = r_borrow;
    assign neg         = r_neg;
    assign dz          = r_dz;
    assign ill         = r_ill;

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq_param;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bgn = 1'b0;
    logic [3:0]    control = 4'd0;
    logic [3:0]    pos = 4'd0;
    logic [W-1:0]  nr1 = '0;
    logic [W-1:0]  nr2 = '0;
    logic          busy, done, carry_next, borrow_next, neg, dz, ill;
    logic [2*W-1:0] outbus;

    int checks = 0;
    int errors = 0;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bgn(bgn), .control(control), .pos(pos),
        .nr1(nr1), .nr2(nr2), .busy(busy), .done(done), .outbus(outbus),
        .carry_next(carry_next), .borrow_next(borrow_next), .neg(neg),
        .dz(dz), .ill(ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: flags packed {carry, borrow, neg, dz, ill}.
    task automatic model(input int unsigned c, input int unsigned a, input int unsigned b,
                         input int unsigned p, output int unsigned res,
                         output logic [4:0] fl, output int lat);
        int unsigned s;
        res = 0; fl = 5'b0; lat = 1;
        case (c)
            0: begin s = a + b; res = s % 65536; fl[4] = (s >= 65536); fl[2] = (res >= 32768); end
            1: begin res = (a + 65536 - b) % 65536; fl[3] = (a < b); fl[2] = (res >= 32768); end
            2: begin res = a * b; lat = W + 1; end
            3: begin
                if (b == 0) begin res = a * 65536 + 65535; fl[1] = 1'b1; end
                else begin res = (a % b) * 65536 + (a / b); lat = W + 1; end
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
`ifdef SHIFT_OPS_EN
            7: res = (a << p) % 65536;
            8: res = a >> p;
`endif
            default: fl[0] = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] p, input string tag, input bit poke);
        int unsigned er;
        logic [4:0]  ef;
        int          elat, n, nb;
        model(c, a, b, p, er, ef, elat);
        @(negedge clk);
        control = c; nr1 = a; nr2 = b; pos = p; bgn = 1'b1;
        @(posedge clk);
        #1 bgn = 1'b0;
        n = 0; nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (poke && n == 3) begin bgn = 1'b1; control = 4'd0; end
            else bgn = 1'b0;
        end while (!done && n < 40);
        chk({tag, " latency"}, n, elat);
        chk({tag, " busy_cycles"}, nb, elat - 1);
        chk({tag, " outbus"}, outbus, er);
        chk({tag, " flags"}, {carry_next, borrow_next, neg, dz, ill}, ef);
        @(negedge clk);
        chk({tag, " done_pulse"}, {busy, done}, 2'b00);
        chk({tag, " hold"}, outbus, er);
    endtask

    initial begin
        #12;
        chk("reset outputs", {busy, done, carry_next, borrow_next, neg, dz, ill}, 7'b0);
        chk("reset outbus", outbus, 32'h0);
        @(negedge clk); rst = 1'b0;

        run_op(4'd3, 16'd15, 16'd3, 4'd0, "div 15/3", 1'b0);
        chk("div 15/3 const", outbus, 32'h0000_0005);
        run_op(4'd3, 16'd63, 16'd19, 4'd0, "div 63/19", 1'b0);
        chk("div 63/19 const", outbus, 32'h0006_0003);
        run_op(4'd2, 16'd63, 16'd19, 4'd0, "mul 63*19", 1'b0);
        chk("mul 63*19 const", outbus, 32'h0000_04AD);
        run_op(4'd2, 16'hFFFF, 16'hFFFF, 4'd0, "mul ffff", 1'b0);
        chk("mul ffff const", outbus, 32'hFFFE_0001);
        run_op(4'd0, 16'hFFFF, 16'h0001, 4'd0, "add wrap", 1'b0);
        chk("add wrap carry", carry_next, 1'b1);
        run_op(4'd1, 16'd3, 16'd15, 4'd0, "sub 3-15", 1'b0);
        chk("sub 3-15 const", {outbus, borrow_next, neg}, {32'h0000_FFF4, 2'b11});
        run_op(4'd1, 16'd15, 16'd3, 4'd0, "sub 15-3", 1'b0);
        chk("sub 15-3 const", {outbus, borrow_next, neg}, {32'h0000_000C, 2'b00});
        run_op(4'd4, 16'h080F, 16'h0603, 4'd0, "and", 1'b0);
        chk("and const", outbus, 32'h0000_0003);
        run_op(4'd5, 16'h080F, 16'h0603, 4'd0, "or", 1'b0);
        chk("or const", outbus, 32'h0000_0E0F);
        run_op(4'd6, 16'h080F, 16'h0603, 4'd0, "xor", 1'b0);
        chk("xor const", outbus, 32'h0000_0E0C);
        run_op(4'd7, 16'h080F, 16'h0603, 4'd4, "shl", 1'b0);
        run_op(4'd8, 16'h080F, 16'h0603, 4'd3, "shr", 1'b0);
        run_op(4'd15, 16'h1234, 16'h5678, 4'd0, "ill 1111", 1'b0);
        chk("ill 1111 const", {outbus, ill}, {32'h0, 1'b1});
        run_op(4'd3, 16'h1234, 16'h0000, 4'd0, "div by zero", 1'b0);
        chk("div0 const", {outbus, dz}, {32'h1234_FFFF, 1'b1});
        run_op(4'd2, 16'h0ABC, 16'h0123, 4'd0, "mul bgn poke", 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  c;
            logic [15:0] a, b;
            c = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            run_op(c, a, b, 4'($urandom), $sformatf("rand%0d op%0d", i, c), 1'b0);
        end

        // Reset in cycle T+5 of a multiply.
        @(negedge clk);
        control = 4'd2; nr1 = 16'h1357; nr2 = 16'h2468; bgn = 1'b1;
        @(posedge clk);
        #1 bgn = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid-op reset outputs", {busy, done, carry_next, borrow_next, neg, dz, ill}, 7'b0);
        chk("mid-op reset outbus", outbus, 32'h0);
        chk("mid-op reset state", dut.r_state, 2'b00);
        @(negedge clk); rst = 1'b0;
        run_op(4'd0, 16'h8000, 16'h7FFF, 4'd0, "add after reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised multi-cycle ALU, WIDTH-bit operands, 2*WIDTH-bit result bus. Single-cycle add/sub/logic ops. Iterative shift-add multiply and restoring divide, one bit per clock. Start/busy/done handshake so a sequencer or CPU stub can issue ops back-to-back.

Parameters:
WIDTH, 16, operand width; legal values 4..32, result is 2*WIDTH
CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
bgn  input  1  start request, level-sampled in IDLE only
control  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 AND, 0101 OR, 0110 XOR, 0111 SHL, 1000 SHR
pos  input  $clog2(WIDTH)  shift amount (used only with SHIFT_OPS_EN)
nr1  input  WIDTH  operand A
nr2  input  WIDTH  operand B
busy  output  1  high while an op is in progress
done  output  1  one-cycle pulse, result valid
outbus  output  2*WIDTH  result, held until next accept
carry_next  output  1  carry out of add
borrow_next  output  1  borrow of sub (nr1 < nr2 unsigned)
neg  output  1  MSB of WIDTH-bit add/sub result
dz  output  1  divide-by-zero flag
ill  output  1  illegal opcode flag

Behaviour:
- Async reset (rst high): state IDLE; busy, done, outbus, carry_next, borrow_next, neg, dz, ill all 0. Reset mid-operation aborts immediately; no partial result is retained.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: cycle T with state IDLE and bgn=1. Latch nr1, nr2, control, pos. Clear all flags and dz/ill.
- bgn is ignored outside IDLE. DONE lasts exactly one cycle and then returns to IDLE. If bgn is still high in IDLE, a new op is accepted (level semantics).
- Single-cycle ops (add, sub, logic, shift): IDLE->DONE at edge T. In cycle T+1: done=1, busy=0, outbus valid.
- add: outbus = zero-extended {WIDTH'b0, sum[WIDTH-1:0]}; carry_next = bit WIDTH of the sum.
- sub: outbus low half = nr1 - nr2 mod 2^WIDTH; upper half 0; borrow_next = (nr1 < nr2).
- neg is updated on add and sub only; it is 0 for all other ops.
- Logic ops: bitwise on WIDTH bits, upper half 0.
- mul (unsigned): IDLE->MUL, busy=1 in cycles T+1..T+WIDTH. One add/shift per cycle, LSB first. DONE in cycle T+WIDTH+1. outbus = full 2*WIDTH product.
- div (unsigned restoring): same timing as mul. outbus[WIDTH-1:0] = quotient, outbus[2*WIDTH-1:WIDTH] = remainder.
- div with nr2=0: no iteration. DONE in cycle T+1 with dz=1, quotient all ones, remainder = nr1.
- Illegal opcode (1001..1111, and 0111/1000 without the macro): DONE in cycle T+1, outbus=0, ill=1.
- Flags and outbus hold their values until the next accept or reset.

Optional Feature:
SHIFT_OPS_EN
- Defined: opcode 0111 = logical left shift of nr1 by pos; opcode 1000 = logical right shift of nr1 by pos. Result is WIDTH bits, zero-extended. Both are single-cycle ops.
- Undefined: pos is unused and both opcodes are treated as illegal (ill=1).

Decomposition:
- Package alu_pkg holds: opcode localparams (OP_ADD..OP_SHR) and the state enum (S_IDLE, S_MUL, S_DIV, S_DONE).
- One sub-module, alu_seq_muldiv: the iterative datapath. It contains the accumulator/remainder register, the shift register and the iteration counter, and takes start, mode (mul/div) and operands. It returns result and a last-iteration strobe.
- The top level contains the FSM, the single-cycle ops and the flag registers.

Test Plan:
All scenarios use WIDTH=16, with SHIFT_OPS_EN defined except where stated.
- div 15/3: done at T+17, outbus=0x0000_0005, dz=0. div 63/19: outbus=0x0006_0003.
- mul 63*19: busy for 16 cycles, done at T+17, outbus=0x0000_04AD. mul 0xFFFF*0xFFFF: outbus=0xFFFE_0001.
- add 0xFFFF+0x0001: outbus=0, carry_next=1, done at T+1. sub 3-15: outbus=0x0000_FFF4, borrow_next=1, neg=1. sub 15-3: outbus=0x0000_000C, borrow_next=0, neg=0.
- nr1=0x080F, nr2=0x0603: AND gives 0x0003, OR gives 0x0E0F, XOR gives 0x0E0C. SHL with pos=4 gives 0x80F0. Opcode 1111: ill=1, outbus=0. Build without macro, opcode 0111: ill=1.
- div 0x1234/0: done at T+1, dz=1, outbus=0x1234_FFFF.
- Assert rst at cycle T+5 of a mul: all outputs 0 and state IDLE immediately. A new add issued after reset completes correctly. bgn pulsed during busy is ignored.
